// File: rtl/dm_access_unit_if.sv
// Data-memory port bundle between the M-stage access unit and the memory.
// The unit drives the request side; the memory returns ack and read data.
interface dm_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dm_access_unit.sv
// M-stage data-memory bridge: turns decoded load/store controls into a registered
// req/ack transaction, stalls the pipeline until it completes, and extends load data.
module dm_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [1:0]       writedm_op,
    input  logic             m_load,
    input  logic [2:0]       readdm_op,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             stall,
    output logic [31:0]      rdata_ext,
    output logic             rdata_valid,
    output logic             align_err,
    output logic             bus_err,
    dm_access_unit_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  lane_q;
    logic [2:0]  op_q;
    logic        abort_q;
    logic        align_err_q;
    logic [31:0] ext_q;

    logic        is_store;
    logic        access;
    logic        aligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'b001:  return {{24{b[7]}}, b};
            3'b010:  return {24'h0, b};
            3'b011:  return {{16{h[15]}}, h};
            3'b100:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    assign is_store = memwrite && (writedm_op != 2'b11);
    assign access   = is_store || m_load;

    always_comb begin
        aligned  = 1'b1;
        st_be    = 4'b1111;
        st_wdata = wdata;
        if (is_store) begin
            case (writedm_op)
                2'b01: begin
                    st_be    = 4'b0001 << addr[1:0];
                    st_wdata = {4{wdata[7:0]}};
                end
                2'b10: begin
                    aligned  = ~addr[0];
                    st_be    = addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{wdata[15:0]}};
                end
                default: aligned = (addr[1:0] == 2'b00);
            endcase
        end else begin
            case (readdm_op)
                3'b001, 3'b010: aligned = 1'b1;
                3'b011, 3'b100: aligned = ~addr[0];
                default:        aligned = (addr[1:0] == 2'b00);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lane_q      <= '0;
            op_q        <= '0;
            abort_q     <= 1'b0;
            align_err_q <= 1'b0;
            ext_q       <= '0;
        end else begin
            align_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (access && aligned) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        be_q    <= is_store ? st_be : 4'b1111;
                        addr_q  <= addr[31:2];
                        wdata_q <= is_store ? st_wdata : 32'h0;
                        lane_q  <= addr[1:0];
                        op_q    <= readdm_op;
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                        ext_q   <= '0;
                        state_q <= StReq;
                    end else if (access) begin
                        align_err_q <= 1'b1;
                    end
                end
                StReq: begin
                    // An ack in the final wait cycle takes priority over the timeout.
                    if (bus.mem_ack) begin
                        req_q   <= 1'b0;
                        ext_q   <= we_q ? 32'h0 : extend(bus.mem_rdata, lane_q, op_q);
                        state_q <= StResp;
                    end else if (cnt_q == LastCnt) begin
                        req_q   <= 1'b0;
                        abort_q <= 1'b1;
                        ext_q   <= '0;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    abort_q <= 1'b0;
                    ext_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall       = (state_q == StReq) || ((state_q == StIdle) && access && aligned);
    assign rdata_ext   = ext_q;
    assign rdata_valid = (state_q == StResp) && !we_q && !abort_q;
    assign bus_err     = (state_q == StResp) && abort_q;
    assign align_err   = align_err_q;

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: table of accesses with a scoreboard of
// expected completion strobes, plus hand sequences for reset handling.
module tb_dm_access_unit;
    localparam int unsigned TIMEOUT = 4;
    localparam int          WINDOW  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [1:0]  writedm_op;
    logic        m_load;
    logic [2:0]  readdm_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata_ext;
    logic        rdata_valid;
    logic        align_err;
    logic        bus_err;

    dm_access_unit_if bus ();

    dm_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .writedm_op (writedm_op),
        .m_load     (m_load),
        .readdm_op  (readdm_op),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata_ext  (rdata_ext),
        .rdata_valid(rdata_valid),
        .align_err  (align_err),
        .bus_err    (bus_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // kind: 0 no strobe, 1 rdata_valid, 2 bus_err, 3 align_err
    typedef struct {
        logic        mw;
        logic [1:0]  wop;
        logic        ld;
        logic [2:0]  rop;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_kind;
        logic [31:0] e_rdata;
        int          e_stall;
        int          e_req;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // lat 0 = memory never acks; misaligned accesses never stall or request.
    function automatic vec_t mk(input logic mw, input logic [1:0] wop, input logic ld,
                                input logic [2:0] rop, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input int lat,
                                input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_wd, input int kind,
                                input logic [31:0] e_rd);
        vec_t v;
        v.mw = mw; v.wop = wop; v.ld = ld; v.rop = rop; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.lat = lat; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wd;
        v.e_kind = kind; v.e_rdata = e_rd;
        if (kind == 3 || (!ld && !(mw && wop != 2'b11))) begin
            v.e_stall = 0; v.e_req = 0;
        end else if (lat == 0) begin
            v.e_stall = TIMEOUT + 1; v.e_req = TIMEOUT;
        end else begin
            v.e_stall = lat + 1; v.e_req = lat;
        end
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int stall_cnt = 0;
        int req_cnt   = 0;
        logic stall_s;
        exp_t e;
        memwrite = v.mw; writedm_op = v.wop; m_load = v.ld; readdm_op = v.rop;
        addr = v.addr; wdata = v.wdata;
        if (v.e_kind != 0) begin
            e.kind = v.e_kind; e.rdata = v.e_rdata;
            sb_q.push_back(e);
        end
        for (int c = 0; c < WINDOW; c++) begin
            #1;
            stall_s = stall;
            if (stall) stall_cnt++;
            if (bus.mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check($sformatf("v%0d mem_we", idx), {31'h0, bus.mem_we}, {31'h0, v.e_we});
                    check($sformatf("v%0d mem_be", idx), {28'h0, bus.mem_be}, {28'h0, v.e_be});
                    check($sformatf("v%0d mem_addr", idx), {2'b0, bus.mem_addr},
                          {2'b0, v.addr[31:2]});
                    if (v.e_we)
                        check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.e_wdata);
                end
                bus.mem_ack   = (v.lat != 0) && (req_cnt == v.lat);
                bus.mem_rdata = v.rdata;
            end
            if (rdata_valid || bus_err || align_err) begin
                check($sformatf("v%0d strobe_excl", idx),
                      32'(int'(rdata_valid) + int'(bus_err) + int'(align_err)), 32'd1);
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL v%0d unexpected_strobe: got rv=%b ae=%b be=%b, expected none",
                             idx, rdata_valid, align_err, bus_err);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d strobe_kind", idx),
                          rdata_valid ? 32'd1 : bus_err ? 32'd2 : 32'd3, 32'(e.kind));
                    if (e.kind != 3)
                        check($sformatf("v%0d rdata_ext", idx), rdata_ext, e.rdata);
                end
            end
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (!stall_s) begin
                memwrite = 1'b0; m_load = 1'b0; writedm_op = 2'b00; readdm_op = 3'b000;
            end
            @(negedge clk);
        end
        check($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.e_stall));
        check($sformatf("v%0d req_cycles", idx), 32'(req_cnt), 32'(v.e_req));
        check($sformatf("v%0d pending_strobes", idx), 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int strobes;
        reset = 1'b1; memwrite = 1'b0; writedm_op = 2'b00; m_load = 1'b0; readdm_op = 3'b000;
        addr = '0; wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        //       mw   wop   ld   rop     addr          wdata         rdata       lat we  be
        vecs.push_back(mk(1, 2'b01, 0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1,
                          1, 4'b1000, 32'hABAB_ABAB, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 3'b001, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1,
                          0, 4'b1111, 32'h0, 1, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 2'b00, 1, 3'b010, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1,
                          0, 4'b1111, 32'h0, 1, 32'h0000_0080));
        vecs.push_back(mk(0, 2'b00, 1, 3'b011, 32'h0000_2002, 32'h0, 32'h1234_80FF, 1,
                          0, 4'b1111, 32'h0, 1, 32'h0000_1234));
        vecs.push_back(mk(0, 2'b00, 1, 3'b011, 32'h0000_0003, 32'h0, 32'h0, 1,
                          0, 4'b0000, 32'h0, 3, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 3'b000, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1,
                          1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 3'b000, 32'h0000_0008, 32'h0123_4567, 32'h0, 3,
                          1, 4'b1111, 32'h0123_4567, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 3'b000, 32'h0000_0010, 32'h0, 32'h5555_5555, 0,
                          0, 4'b1111, 32'h0, 2, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 3'b000, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 4,
                          0, 4'b1111, 32'h0, 1, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 2'b00, 1, 3'b100, 32'h0000_2000, 32'h0, 32'hF00D_8765, 2,
                          0, 4'b1111, 32'h0, 1, 32'h0000_8765));
        vecs.push_back(mk(0, 2'b00, 1, 3'b011, 32'h0000_2000, 32'h0, 32'hF00D_8765, 1,
                          0, 4'b1111, 32'h0, 1, 32'hFFFF_8765));
        vecs.push_back(mk(1, 2'b01, 0, 3'b000, 32'h0000_1001, 32'hFFFF_FF55, 32'h0, 1,
                          1, 4'b0010, 32'h5555_5555, 0, 32'h0));
        vecs.push_back(mk(1, 2'b11, 0, 3'b000, 32'h0000_0020, 32'h1111_1111, 32'h0, 1,
                          0, 4'b0000, 32'h0, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 1, 3'b001, 32'h0000_0030, 32'h7777_8888, 32'h0, 1,
                          1, 4'b1111, 32'h7777_8888, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 3'b111, 32'h0000_0020, 32'h0, 32'h89AB_CDEF, 2,
                          0, 4'b1111, 32'h0, 1, 32'h89AB_CDEF));
        vecs.push_back(mk(1, 2'b00, 0, 3'b000, 32'h0000_0002, 32'h1234_5678, 32'h0, 1,
                          0, 4'b0000, 32'h0, 3, 32'h0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset strobes", {29'h0, rdata_valid, align_err, bus_err}, 32'h0);
        check("reset rdata_ext", rdata_ext, 32'h0);
        check("reset mem_req_we_be", {27'h0, bus.mem_req, bus.mem_we, bus.mem_be}, 32'h0);
        check("reset mem_addr", {2'b0, bus.mem_addr}, 32'h0);
        check("reset mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset while in the second REQ cycle of a load that is never acked.
        m_load = 1'b1; readdm_op = 3'b000; addr = 32'h0000_0040;
        #1;
        check("rst_seq idle stall", {31'h0, stall}, 32'h1);
        @(negedge clk);
        check("rst_seq req1", {31'h0, bus.mem_req}, 32'h1);
        @(negedge clk);
        check("rst_seq req2", {31'h0, bus.mem_req}, 32'h1);
        reset = 1'b1; m_load = 1'b0; addr = '0;
        @(negedge clk);
        check("rst_seq outputs", {26'h0, stall, rdata_valid, align_err, bus_err, bus.mem_req,
                                  bus.mem_we}, 32'h0);
        check("rst_seq mem_be_addr", {bus.mem_be, {2'b0, bus.mem_addr[25:0]}}, 32'h0);
        check("rst_seq mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_seq rdata_ext", rdata_ext, 32'h0);
        reset = 1'b0;
        strobes = 0;
        repeat (TIMEOUT + 3) begin
            @(negedge clk);
            strobes += int'(rdata_valid) + int'(bus_err) + int'(align_err) + int'(bus.mem_req);
        end
        check("rst_seq no_strobe_after", 32'(strobes), 32'h0);
        run_vec(100, mk(1, 2'b10, 0, 3'b000, 32'h0000_0006, 32'h1234_ABCD, 32'h0, 2,
                        1, 4'b1100, 32'hABCD_ABCD, 0, 32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Memory-stage data-memory bridge for the pipelined MIPS CPU. It consumes the M-stage decoded store and load controls (`memwrite`, `writedm_op`, `m_load`, `readdm_op`) together with the address and store data. It turns them into a registered req/ack transaction on the data-memory port, with byte enables and lane-replicated write data. It stalls the pipeline until the transaction completes, then returns the sign- or zero-extended load result to the M/W register.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum `mem_req` cycles without `mem_ack` before the access is aborted. Legal range is 1–255.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  M-stage store indicator.
- `writedm_op`  in  2  store width: 00 word, 01 byte, 10 half, 11 none.
- `m_load`  in  1  M-stage load indicator.
- `readdm_op`  in  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 are treated as lw.
- `addr`  in  32  byte address, which is the ALU result.
- `wdata`  in  32  store data (rt, after forwarding).
- `stall`  out  1  freezes PC, F, D, E and M registers while high.
- `rdata_ext`  out  32  extended load result, valid while `rdata_valid` is high.
- `rdata_valid`  out  1  one-cycle completion strobe for loads.
- `align_err`  out  1  one-cycle misaligned-access strobe.
- `bus_err`  out  1  one-cycle timeout strobe.
- `mem_req`  out  1  memory request, held high until acknowledged or aborted.
- `mem_we`  out  1  1 means write.
- `mem_be`  out  4  byte enables; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_addr`  out  30  word address, equal to `addr[31:2]`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completion. For reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- **Access condition:** an access exists when `(memwrite && writedm_op != 2'b11) || m_load`. If both are high, the store wins.
- **Alignment rules:**
  - A word access requires `addr[1:0]==0`.
  - A half access requires `addr[0]==0`.
  - Byte accesses are always aligned.
- **State machine:** three states, IDLE, REQ and RESP.
  - **IDLE:**
    - An aligned access drives `stall`=1 combinationally.
    - On the clock edge it latches `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `addr[1:0]` and `readdm_op`, sets `mem_req`=1, clears the wait counter, and moves to REQ.
    - A misaligned access pulses `align_err` for one cycle, issues no request, holds `stall`=0 and stays in IDLE.
    - With no access, the unit idles.
  - **REQ:**
    - `stall`=1 throughout.
    - If `mem_ack`=1: capture `mem_rdata`, drop `mem_req`, go to RESP.
    - Else if the counter equals `TIMEOUT-1`: drop `mem_req`, set the abort flag, go to RESP.
    - Otherwise: increment the counter and stay in REQ.
  - **RESP:** lasts exactly one cycle.
    - `stall`=0, so the pipeline advances the instruction at the end of this cycle.
    - Loads: `rdata_valid`=1.
    - Aborted accesses: `bus_err`=1 and `rdata_ext`=0.
    - The next state is always IDLE; inputs are ignored in this cycle.
- **Store byte enables and data:**
  - Word: `mem_be`=1111, `mem_wdata`=`wdata`.
  - Half: `mem_be`=0011 if `addr[1]`=0, else 1100. `mem_wdata`=`{wdata[15:0],wdata[15:0]}`.
  - Byte: `mem_be`=`1<<addr[1:0]`. `mem_wdata`=`{4{wdata[7:0]}}`.
  - Loads: `mem_we`=0 and `mem_be`=1111.
- **Load extension:** uses the latched `addr[1:0]` and the latched `readdm_op`.
  - The selected byte is `rdata[8*a+7:8*a]`; the selected half is `rdata[16*a1+15:16*a1]`.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- **`mem_ack` outside REQ:** ignored.

## Timing
- **Reset values:** the state is IDLE, and all outputs are 0 (`stall`, `rdata_ext`, `rdata_valid`, `align_err`, `bus_err`, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`).
- **Reset in REQ:** `mem_req` falls at that edge and no strobe is produced. Memory must tolerate an abandoned request.
- **Latency with zero-wait memory** (`mem_ack` high in the first REQ cycle): `stall` is high for 2 cycles (IDLE and REQ), and the RESP cycle follows.
- **Latency with N-cycle ack** (ack in the Nth REQ cycle, 1 ≤ N ≤ `TIMEOUT`): `stall` is high for N+1 cycles, and `mem_req` is high for exactly N cycles.
- **Timeout:** `mem_req` stays high for exactly `TIMEOUT` cycles. An ack arriving in the last REQ cycle wins over the timeout and produces no `bus_err`.
- **Registered outputs:** `mem_*` are driven directly from flops.
- **Combinational outputs:** `stall` is combinational in IDLE only. `rdata_ext` and the strobes are registered, or decoded from state.
- **Strobe exclusivity:** at most one of `rdata_valid`, `align_err` and `bus_err` is high in any cycle.

## Test plan
1. **Byte store:** `sb`, `addr`=0x00001003, `wdata`=0x000000AB, ack in the first REQ cycle. Required: `mem_be`=1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x00000400, `mem_we`=1; `stall` high for 2 cycles, then low; no strobes.
2. **Byte loads, sign and zero extension:** `lb` at 0x2001 with `mem_rdata`=0x123480FF gives `rdata_ext`=0xFFFFFF80 and `rdata_valid` for one cycle. `lbu` at the same address gives 0x00000080. `lh` at 0x2002 gives 0x00001234.
3. **Misaligned halfword:** `lh` at 0x00000003 gives `align_err`=1 for one cycle, `mem_req` never rises, and `stall` stays 0. A following `sw` at 0x4 proceeds normally.
4. **Wait states:** `sw` with ack on the third REQ cycle. Required: `mem_req` high 3 cycles, `stall` high 4 cycles, `mem_be`=1111, and the RESP cycle has `stall`=0.
5. **Timeout:** with `TIMEOUT`=4, a `lw` that is never acked gives `mem_req` high exactly 4 cycles, then `bus_err`=1 with `rdata_ext`=0 for one cycle, then IDLE. Repeat with ack in the 4th cycle: required `rdata_valid`=1 and no `bus_err`.
6. **Reset mid-access:** assert `reset` in the second REQ cycle. Required: all outputs are 0 on the next cycle and no strobe is emitted. A new `sh` at 0x6 afterwards produces `mem_be`=1100.
